key_event_encoder: RTL and testbench

KEY_EVENT_ENCODER -- requirements
Module: key_event_encoder

---
 rtl/key_event_encoder.sv | 137 +++++++++++++
 tb/tb_key_event_encoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/key_event_encoder.sv
// Key event encoder: synchronizes and debounces five button inputs, then
// tracks one latched key at a time and reports press / hold / release events
// as a registered 7-bit word {event[1:0], one_hot_key[4:0]}.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no key latched, output 7'h00, waiting for a debounced press
// S_PRESS   | one-cycle press event {01,key} for the latched key
// S_HOLD    | {11,key} every cycle while the latched key stays pressed
// S_RELEASE | one-cycle release event {10,key}, then back to idle
//
// Output flops are loaded with the word that belongs to the next state, so
// keyboard_input changes on the same edge the state does and is driven
// straight from flops.
module key_event_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [4:0] key_raw,
  output logic [6:0] keyboard_input
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESS   = 2'd1,
    S_HOLD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  logic [4:0]       r_sync1;
  logic [4:0]       r_sync2;
  logic [4:0]       r_deb;
  logic [CNT_W-1:0] r_cnt [5];

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_key;
  logic [4:0] w_key_next;
  logic [6:0] w_out_next;
  logic [4:0] w_pri;
  logic       w_key_held;

  // Two-flop synchronizer on every raw key level.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Independent per-key debouncer: a level change is accepted only after it
  // has been seen for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_deb <= '0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Highest-numbered pressed key wins when several are down at once.
  always_comb begin
    w_pri = 5'b00000;
    if      (r_deb[4]) w_pri = 5'b10000;
    else if (r_deb[3]) w_pri = 5'b01000;
    else if (r_deb[2]) w_pri = 5'b00100;
    else if (r_deb[1]) w_pri = 5'b00010;
    else if (r_deb[0]) w_pri = 5'b00001;
  end

  assign w_key_held = |(r_deb & r_key);

  // Next-state, latched key and next output word.
  always_comb begin
    w_next     = r_state;
    w_key_next = r_key;
    w_out_next = 7'b0000000;
    case (r_state)
      S_IDLE: begin
        if (|r_deb) begin
          w_next     = S_PRESS;
          w_key_next = w_pri;
          w_out_next = {2'b01, w_pri};
        end
      end
      S_PRESS, S_HOLD: begin
        if (w_key_held) begin
          w_next     = S_HOLD;
          w_out_next = {2'b11, r_key};
        end else begin
          w_next     = S_RELEASE;
          w_out_next = {2'b10, r_key};
        end
      end
      S_RELEASE: begin
        w_next     = S_IDLE;
        w_key_next = 5'b00000;
      end
      default: begin
        w_next     = S_IDLE;
        w_key_next = 5'b00000;
      end
    endcase
  end

  // State, latched key and output register; reset drops any event silently.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_key          <= 5'b00000;
      keyboard_input <= 7'b0000000;
    end else begin
      r_state        <= w_next;
      r_key          <= w_key_next;
      keyboard_input <= w_out_next;
    end
  end

endmodule

// File: tb/tb_key_event_encoder.sv
// Bench for key_event_encoder with DEBOUNCE_CYCLES = 4. Stimulus pushes the
// expected output words and the cycle at which each should first appear; a
// monitor pops an entry every time keyboard_input changes.
module tb_key_event_encoder;

  localparam int DC  = 4;
  localparam int LAT = DC + 3;  // drive cycle -> first visible output cycle

  typedef struct {
    logic [6:0] val;
    int         cyc;
  } exp_t;

  logic       clock;
  logic       rst;
  logic [4:0] key_raw;
  logic [6:0] keyboard_input;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_evt  = 0;
  bit   mon_en = 0;
  logic [6:0] prev = 7'h00;
  exp_t q[$];

  key_event_encoder #(.DEBOUNCE_CYCLES(DC), .CNT_W(20)) dut (
    .clock         (clock),
    .rst           (rst),
    .key_raw       (key_raw),
    .keyboard_input(keyboard_input)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic push(input logic [6:0] v, input int c);
    exp_t e;
    e.val = v;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: every change of the output word is one event to check.
  always @(negedge clock) begin
    if (mon_en && keyboard_input !== prev) begin
      exp_t e;
      checks = checks + 1;
      n_evt  = n_evt + 1;
      if (q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL evt%0d unexpected output got %h at cycle %0d exp none", n_evt, keyboard_input, cyc);
      end else begin
        e = q.pop_front();
        if (keyboard_input !== e.val || cyc != e.cyc) begin
          errors = errors + 1;
          $display("FAIL evt%0d got %h at cycle %0d exp %h at cycle %0d", n_evt, keyboard_input, cyc, e.val, e.cyc);
        end
      end
      prev = keyboard_input;
    end
  end

  initial begin
    int t;
    rst     = 1'b1;
    key_raw = 5'b00000;
    tick(3);
    rst = 1'b0;
    checks = checks + 1;
    if (keyboard_input !== 7'h00) begin
      errors = errors + 1;
      $display("FAIL reset_state got %h exp 00", keyboard_input);
    end
    mon_en = 1;
    tick(2);

    // Single press of forward
    key_raw = 5'b10000; t = cyc;
    push(7'h30, t + LAT); push(7'h70, t + LAT + 1);
    tick(20);
    key_raw = 5'b00000; t = cyc;
    push(7'h50, t + LAT); push(7'h00, t + LAT + 1);
    tick(15);

    // Glitch shorter than the debounce window
    key_raw = 5'b00001;
    tick(3);
    key_raw = 5'b00000;
    tick(15);

    // Pulse exactly DEBOUNCE_CYCLES long is accepted
    key_raw = 5'b00001; t = cyc;
    push(7'h21, t + LAT); push(7'h61, t + LAT + 1);
    tick(DC);
    key_raw = 5'b00000; t = cyc;
    push(7'h41, t + LAT); push(7'h00, t + LAT + 1);
    tick(15);

    // Simultaneous angle_up + angle_down
    key_raw = 5'b00110; t = cyc;
    push(7'h24, t + LAT); push(7'h64, t + LAT + 1);
    tick(15);
    key_raw = 5'b00010; t = cyc;
    push(7'h44, t + LAT); push(7'h00, t + LAT + 1);
    push(7'h22, t + LAT + 2); push(7'h62, t + LAT + 3);
    tick(15);
    key_raw = 5'b00000; t = cyc;
    push(7'h42, t + LAT); push(7'h00, t + LAT + 1);
    tick(15);

    // Overlap: backward held, forward added, backward released
    key_raw = 5'b01000; t = cyc;
    push(7'h28, t + LAT); push(7'h68, t + LAT + 1);
    tick(12);
    key_raw = 5'b11000;
    tick(12);
    key_raw = 5'b10000; t = cyc;
    push(7'h48, t + LAT); push(7'h00, t + LAT + 1);
    push(7'h30, t + LAT + 2); push(7'h70, t + LAT + 3);
    tick(15);
    key_raw = 5'b00000; t = cyc;
    push(7'h50, t + LAT); push(7'h00, t + LAT + 1);
    tick(15);

    // Reset mid-hold with key still down
    key_raw = 5'b10000; t = cyc;
    push(7'h30, t + LAT); push(7'h70, t + LAT + 1);
    tick(15);
    rst = 1'b1; t = cyc;
    push(7'h00, t + 1);
    tick(1);
    rst = 1'b0;
    push(7'h30, t + 1 + DC + 3); push(7'h70, t + 1 + DC + 4);
    tick(15);
    key_raw = 5'b00000; t = cyc;
    push(7'h50, t + LAT); push(7'h00, t + LAT + 1);
    tick(15);

    // Bounce on angle_up, then stable high
    for (int i = 0; i < 5; i++) begin
      key_raw = 5'b00100;
      tick(2);
      key_raw = 5'b00000;
      tick(2);
    end
    key_raw = 5'b00100; t = cyc;
    push(7'h24, t + LAT); push(7'h64, t + LAT + 1);
    tick(15);
    key_raw = 5'b00000; t = cyc;
    push(7'h44, t + LAT); push(7'h00, t + LAT + 1);
    tick(20);

    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL missing_events got %0d pending exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
